// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART word receiver
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
   localparam int CLKS_PER_BIT_DEF = 4988;
   localparam int WORD_BYTES = 4;
   localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver with input synchronizer and break hold-off
// Ports: clk, rst (sync, active-high); rx_in (async serial, idle high);
//        rx_byte (last received byte); byte_done (1-cycle, good stop bit);
//        stop_err (1-cycle, bad stop bit); start_det (start edge seen in IDLE);
//        idle (receiver in IDLE)
module uart_byte_rx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_in,
   output logic [BITS_PER_BYTE-1:0] rx_byte,
   output logic                     byte_done,
   output logic                     stop_err,
   output logic                     start_det,
   output logic                     idle
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   rx_state_e state, state_n;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [BITS_PER_BYTE-1:0] sh, sh_n;
   logic done_n, err_n;
   assign idle = state == IDLE;
   assign start_det = idle && !rx_s;
   assign rx_byte = sh;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         sh <= '0;
         byte_done <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
         state <= state_n;
         cnt <= cnt_n;
         bit_cnt <= bit_cnt_n;
         sh <= sh_n;
         byte_done <= done_n;
         stop_err <= err_n;
      end
   end
   // Start bit is re-checked at mid-bit; every later sample lands one full bit later.
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      bit_cnt_n = bit_cnt;
      sh_n = sh;
      done_n = 1'b0;
      err_n = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            state_n = rx_s ? IDLE : START;
         end
         START: if (cnt == HALF) begin
            cnt_n = '0;
            bit_cnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == FULL) begin
            cnt_n = '0;
            sh_n = {rx_s, sh[BITS_PER_BYTE-1:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            state_n = (bit_cnt == 3'd7) ? STOP : DATA;
         end
         STOP: if (cnt == FULL) begin
            cnt_n = '0;
            done_n = rx_s;
            err_n = !rx_s;
            state_n = rx_s ? IDLE : BREAK;
         end
         BREAK: begin
            cnt_n = '0;
            state_n = rx_s ? IDLE : BREAK;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: assembles four 8N1 bytes (LSB byte first) into a 32-bit word
// Ports: clk, rst (sync, active-high); rx_in (async serial, idle high);
//        data_out (last complete word, byte0 in [7:0]); data_valid (1-cycle);
//        frame_err (1-cycle, bad stop bit or inter-byte timeout);
//        busy (frame in progress or partial word held)
// Macro RX_TIMEOUT_EN: drop a partial word after TIMEOUT_BITS idle bit periods.
module uart_word_rx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int BYTES_PER_WORD = WORD_BYTES,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_in,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        frame_err,
   output logic        busy
);
`ifdef RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
   logic [BITS_PER_BYTE-1:0] rx_byte;
   logic byte_done, stop_err, start_det, idle, timeout;
   logic [1:0] byte_idx;
   logic [31:0] word;
   logic [TW-1:0] tcnt;
   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk(clk), .rst(rst), .rx_in(rx_in), .rx_byte(rx_byte),
      .byte_done(byte_done), .stop_err(stop_err), .start_det(start_det), .idle(idle)
   );
   assign busy = !idle || byte_idx != 2'd0;
   assign timeout = TO_EN && idle && byte_idx != 2'd0 && !start_det && tcnt == TLIM;
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx <= '0;
         word <= '0;
         data_out <= '0;
         data_valid <= 1'b0;
         frame_err <= 1'b0;
         tcnt <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_err <= 1'b0;
         tcnt <= (start_det || !idle || byte_idx == 2'd0) ? '0 : tcnt + 1'b1;
         if (stop_err || timeout) begin
            frame_err <= 1'b1;
            byte_idx <= '0;
         end else if (byte_done) begin
            word[{byte_idx, 3'b000} +: BITS_PER_BYTE] <= rx_byte;
            byte_idx <= (byte_idx == LAST) ? 2'd0 : byte_idx + 2'd1;
            if (byte_idx == LAST) begin
               data_out <= {rx_byte, word[23:0]};
               data_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed self-checking bench for uart_word_rx at 16 clocks per bit
module tb_uart_word_rx;
   localparam int C = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_in = 1'b1;
   logic [31:0] data_out;
   logic data_valid, frame_err, busy;
   logic [31:0] vq[$];
   int n_ferr = 0;
   int n_both = 0;
   int n_cmp = 0;
   int n_err = 0;
   int vb, fb;

   uart_word_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(data_out),
      .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) vq.push_back(data_out);
      if (frame_err) n_ferr++;
      if (data_valid && frame_err) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      return (i >= 0 && i < vq.size()) ? vq[i] : 32'hxxxxxxxx;
   endfunction

   task automatic bit_period(input logic v);
      rx_in = v;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
      bit_period(1'b0);
      for (int i = 0; i < 8; i++) bit_period(b[i]);
      bit_period(stop);
      for (int i = 0; i < idle_bits; i++) bit_period(1'b1);
      rx_in = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w, input int idle_bits);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, idle_bits);
   endtask

   task automatic mark;
      vb = vq.size();
      fb = n_ferr;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      chk("reset data_out", data_out, 32'h0);
      chk("reset data_valid", 32'(data_valid), 32'h0);
      chk("reset frame_err", 32'(frame_err), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      mark();
      send_word(32'hDEADBEEF, 1);
      chk("w1 valid count", 32'(vq.size() - vb), 32'd1);
      chk("w1 value", word_at(vb), 32'hDEADBEEF);
      chk("w1 data_out", data_out, 32'hDEADBEEF);
      chk("w1 frame_err count", 32'(n_ferr - fb), 32'd0);
      chk("w1 busy idle", 32'(busy), 32'h0);

      mark();
      send_word(32'h01234567, 0);
      send_word(32'h89ABCDEF, 0);
      bit_period(1'b1);
      chk("b2b valid count", 32'(vq.size() - vb), 32'd2);
      chk("b2b first", word_at(vb), 32'h01234567);
      chk("b2b second", word_at(vb + 1), 32'h89ABCDEF);
      chk("b2b frame_err count", 32'(n_ferr - fb), 32'd0);

      mark();
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      rx_in = 1'b1;
      chk("glitch busy during", 32'(busy), 32'h1);
      bit_period(1'b1);
      bit_period(1'b1);
      chk("glitch busy after", 32'(busy), 32'h0);
      chk("glitch valid count", 32'(vq.size() - vb), 32'd0);
      chk("glitch frame_err count", 32'(n_ferr - fb), 32'd0);

      mark();
      send_byte(8'h11, 1'b1, 1);
      send_byte(8'h22, 1'b1, 1);
      chk("ferr busy partial", 32'(busy), 32'h1);
      send_byte(8'h33, 1'b0, 0);
      bit_period(1'b1);
      bit_period(1'b1);
      chk("ferr pulse count", 32'(n_ferr - fb), 32'd1);
      chk("ferr valid count", 32'(vq.size() - vb), 32'd0);
      chk("ferr data_out kept", data_out, 32'h89ABCDEF);
      chk("ferr busy cleared", 32'(busy), 32'h0);
      mark();
      send_word(32'hCAFEF00D, 1);
      chk("after ferr valid count", 32'(vq.size() - vb), 32'd1);
      chk("after ferr value", word_at(vb), 32'hCAFEF00D);
      chk("after ferr frame_err", 32'(n_ferr - fb), 32'd0);

      mark();
      send_byte(8'h55, 1'b1, 1);
      bit_period(1'b0);
      bit_period(1'b1);
      bit_period(1'b0);
      rst = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * C) @(negedge clk);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst data_out", data_out, 32'h0);
      chk("rst no pulses", 32'(vq.size() - vb + n_ferr - fb), 32'd0);
      mark();
      send_word(32'h00000001, 1);
      chk("after rst valid count", 32'(vq.size() - vb), 32'd1);
      chk("after rst value", word_at(vb), 32'h00000001);

      mark();
      send_byte(8'hAA, 1'b1, 0);
      send_byte(8'hBB, 1'b1, 0);
      repeat (31) bit_period(1'b1);
`ifdef RX_TIMEOUT_EN
      chk("timeout not early", 32'(n_ferr - fb), 32'd0);
      chk("timeout busy before", 32'(busy), 32'h1);
      repeat (9) bit_period(1'b1);
      chk("timeout pulse", 32'(n_ferr - fb), 32'd1);
      chk("timeout busy after", 32'(busy), 32'h0);
      mark();
      send_word(32'h12345678, 1);
      chk("timeout next word count", 32'(vq.size() - vb), 32'd1);
      chk("timeout next word", word_at(vb), 32'h12345678);
`else
      repeat (9) bit_period(1'b1);
      chk("no timeout pulse", 32'(n_ferr - fb), 32'd0);
      chk("partial busy held", 32'(busy), 32'h1);
      send_byte(8'hCC, 1'b1, 0);
      send_byte(8'hDD, 1'b1, 1);
      chk("partial completes count", 32'(vq.size() - vb), 32'd1);
      chk("partial completes value", word_at(vb), 32'hDDCCBBAA);
`endif
      chk("valid and ferr never together", 32'(n_both), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
